// File: rtl/eth_frame_header_inserter.sv
// Ethernet framer: prepends the MAC header (and an optional 802.1Q tag) to a
// byte-wide payload stream. It zero-pads short payloads to MIN_PAYLOAD and
// drives a registered byte stream downstream.
//
// Handshake: a byte moves on either stream only on a clock edge where
// tvalid and tready are both high. m_axis_* come straight from flops and hold
// while m_axis_tready is low. s_axis_tready is combinational and only rises in
// PAYLOAD when the output register can take a new byte.
module eth_frame_header_inserter #(
  parameter int VLAN_EN     = 0,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [47:0] hdr_mac_dst,
  input  logic [47:0] hdr_mac_src,
  input  logic [15:0] hdr_eth_type,
  input  logic [15:0] hdr_vlan_tci,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_PAD     = 2'd3;

  localparam logic [4:0]  HDR_LAST = (VLAN_EN != 0) ? 5'd17 : 5'd13;
  localparam logic [11:0] MIN_LEN  = 12'(MIN_PAYLOAD);

  logic [1:0]   state;
  logic [4:0]   idx;
  logic [10:0]  count;
  logic [47:0]  dst_q;
  logic [47:0]  src_q;
  logic [15:0]  type_q;
  logic [15:0]  tci_q;
  logic         adv;
  logic [143:0] hdr_vec;
  logic [4:0]   hdr_sel;
  logic [7:0]   hdr_byte;
  logic [11:0]  count_inc;
  logic [10:0]  count_sat;

  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_PAYLOAD) && adv;
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;
  assign count_inc     = {1'b0, count} + 12'd1;
  assign count_sat     = (count == 11'h7FF) ? count : count_inc[10:0];

  // Full tagged header layout. Untagged frames skip bytes 12..15.
  assign hdr_vec = {dst_q, src_q, 16'h8100, tci_q, type_q};

  // Select the header byte for the current index, skipping the tag if disabled
  always_comb begin
    hdr_sel = idx;
    if (VLAN_EN == 0 && idx >= 5'd12) hdr_sel = idx + 5'd4;
    hdr_byte = 8'h00;
    for (int i = 0; i < 18; i++) begin
      if (hdr_sel == 5'(i)) hdr_byte = hdr_vec[(17 - i) * 8 +: 8];
    end
  end

  // Framing FSM, output register and completed-frame counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      idx           <= 5'd0;
      count         <= 11'd0;
      dst_q         <= 48'd0;
      src_q         <= 48'd0;
      type_q        <= 16'd0;
      tci_q         <= 16'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        frame_count <= frame_count + 16'd1;

      case (state)
        ST_IDLE: begin
          if (adv) m_axis_tvalid <= 1'b0;
          if (s_axis_tvalid) begin
            dst_q  <= hdr_mac_dst;
            src_q  <= hdr_mac_src;
            type_q <= hdr_eth_type;
            tci_q  <= hdr_vlan_tci;
            idx    <= 5'd0;
            state  <= ST_HEADER;
          end
        end

        ST_HEADER: begin
          if (adv) begin
            m_axis_tdata  <= hdr_byte;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            idx           <= idx + 5'd1;
            if (idx == HDR_LAST) begin
              count <= 11'd0;
              state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (adv) begin
            if (s_axis_tvalid) begin
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tvalid <= 1'b1;
              count         <= count_sat;
              m_axis_tlast  <= 1'b0;
              if (s_axis_tlast) begin
                if (count_inc >= MIN_LEN) begin
                  m_axis_tlast <= 1'b1;
                  state        <= ST_IDLE;
                end else begin
                  state <= ST_PAD;
                end
              end
            end else begin
              m_axis_tvalid <= 1'b0;
            end
          end
        end

        default: begin // ST_PAD
          if (adv) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b1;
            count         <= count_sat;
            m_axis_tlast  <= 1'b0;
            if (count_inc >= MIN_LEN) begin
              m_axis_tlast <= 1'b1;
              state        <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_header_inserter.sv
// Bench for eth_frame_header_inserter: one untagged instance (MIN 46) and one
// tagged instance (MIN 42). Expected frames are built as byte lists from the
// header fields and payload. A negedge monitor pops and compares them.
module tb_eth_frame_header_inserter;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [47:0] hdr_dst, hdr_src;
  logic [15:0] hdr_type, hdr_tci;

  logic [7:0]  s_tdata [2];
  logic        s_tvalid [2];
  logic        s_tlast [2];
  logic        s_tready [2];
  logic [7:0]  m_tdata [2];
  logic        m_tvalid [2];
  logic        m_tlast [2];
  logic        m_tready [2];
  logic        busy [2];
  logic [15:0] fcount [2];
  logic [1:0]  dbg_state [2];

  eth_frame_header_inserter #(.VLAN_EN(0), .MIN_PAYLOAD(46)) dut (
    .clk(clk), .reset_n(reset_n),
    .hdr_mac_dst(hdr_dst), .hdr_mac_src(hdr_src),
    .hdr_eth_type(hdr_type), .hdr_vlan_tci(hdr_tci),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]),
    .busy(busy[0]), .frame_count(fcount[0]), .dbg_state(dbg_state[0])
  );

  eth_frame_header_inserter #(.VLAN_EN(1), .MIN_PAYLOAD(42)) dut_vlan (
    .clk(clk), .reset_n(reset_n),
    .hdr_mac_dst(hdr_dst), .hdr_mac_src(hdr_src),
    .hdr_eth_type(hdr_type), .hdr_vlan_tci(hdr_tci),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]),
    .busy(busy[1]), .frame_count(fcount[1]), .dbg_state(dbg_state[1])
  );

  // scoreboard state
  logic [8:0] exp_q[$];
  logic [8:0] exp_q_vlan[$];
  logic [7:0] pay_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         out_cnt [2];
  int         exp_frames [2];
  bit         stall_pend [2];
  logic [8:0] stall_val [2];
  bit         no_ready [2];
  bit         rnd_ready [2];
  bit         abort;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired or stray event at %0t", name, $time);
  endtask

  task automatic q_push(input int d, input logic [8:0] v);
    if (d == 1) exp_q_vlan.push_back(v);
    else exp_q.push_back(v);
  endtask

  function automatic int q_size(input int d);
    return (d == 1) ? exp_q_vlan.size() : exp_q.size();
  endfunction

  task automatic q_pop(input int d, output logic [8:0] v);
    if (d == 1) v = exp_q_vlan.pop_front();
    else v = exp_q.pop_front();
  endtask

  function automatic int min_len(input int d);
    return (d == 1) ? 42 : 46;
  endfunction

  // Reference model: a frame is header bytes, payload, zero pad to the
  // minimum, with the end marker on the final byte.
  task automatic model_frame(input int d, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input logic [15:0] tci);
    logic [7:0] bytes[$];
    for (int i = 5; i >= 0; i--) bytes.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) bytes.push_back(src[i*8 +: 8]);
    if (d == 1) begin
      bytes.push_back(8'h81);
      bytes.push_back(8'h00);
      bytes.push_back(tci[15:8]);
      bytes.push_back(tci[7:0]);
    end
    bytes.push_back(typ[15:8]);
    bytes.push_back(typ[7:0]);
    foreach (pay_q[i]) bytes.push_back(pay_q[i]);
    for (int i = pay_q.size(); i < min_len(d); i++) bytes.push_back(8'h00);
    for (int i = 0; i < bytes.size(); i++)
      q_push(d, {(i == bytes.size() - 1) ? 1'b1 : 1'b0, bytes[i]});
  endtask

  // driver: sends pay_q as one frame; optionally swaps hdr_* at payload byte 5
  task automatic send_frame(input int d, input bit chg,
                            input logic [47:0] ndst, input logic [47:0] nsrc,
                            input logic [15:0] ntyp, input logic [15:0] ntci);
    int  len;
    int  wait_cyc;
    bit  ok;
    bit  done;
    len  = pay_q.size();
    model_frame(d, hdr_dst, hdr_src, hdr_type, hdr_tci);
    done = 1'b1;
    for (int i = 0; i < len; i++) begin
      s_tvalid[d] = 1'b1;
      s_tdata[d]  = pay_q[i];
      s_tlast[d]  = (i == len - 1);
      if (chg && i == 5) begin
        hdr_dst = ndst; hdr_src = nsrc; hdr_type = ntyp; hdr_tci = ntci;
      end
      ok = 1'b0;
      wait_cyc = 0;
      while (!ok && !abort && wait_cyc < 400) begin
        @(negedge clk);
        ok = s_tready[d];
        @(posedge clk);
        #1;
        wait_cyc++;
      end
      if (abort) begin done = 1'b0; break; end
      if (!ok) begin fail_now("accept_timeout"); done = 1'b0; break; end
    end
    s_tvalid[d] = 1'b0;
    s_tlast[d]  = 1'b0;
    if (done) begin
      exp_frames[d]++;
      if (len < min_len(d)) no_ready[d] = 1'b1;
    end
  endtask

  task automatic wait_drain(input int d);
    int t;
    t = 0;
    while (q_size(d) != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (q_size(d) != 0) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'(i));
  endtask

  task automatic fill_rand(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // monitor: compare every output handshake, check stall stability
  task automatic mon_step(input int d);
    logic [8:0] got;
    logic [8:0] e;
    if (!reset_n) begin
      stall_pend[d] = 1'b0;
      no_ready[d]   = 1'b0;
      return;
    end
    got = {m_tlast[d], m_tdata[d]};
    if (stall_pend[d]) begin
      check("stall_valid", 32'(m_tvalid[d]), 32'd1);
      check("stall_hold", 32'(got), 32'(stall_val[d]));
    end
    stall_pend[d] = m_tvalid[d] && !m_tready[d];
    stall_val[d]  = got;
    if (no_ready[d]) check("pad_s_tready", 32'(s_tready[d]), 32'd0);
    if (m_tvalid[d] && m_tready[d]) begin
      if (q_size(d) == 0) fail_now("unexpected_byte");
      else begin
        q_pop(d, e);
        check((d == 1) ? "vlan_byte" : "out_byte", 32'(got), 32'(e));
        out_cnt[d]++;
      end
      if (m_tlast[d]) no_ready[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // downstream ready: always high or 50% random per DUT
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      m_tready[d] = rnd_ready[d] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    reset_n = 1'b0;
    abort   = 1'b0;
    hdr_dst = 48'd0; hdr_src = 48'd0; hdr_type = 16'd0; hdr_tci = 16'd0;
    for (int d = 0; d < 2; d++) begin
      s_tdata[d] = 8'd0; s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0;
      m_tready[d] = 1'b1; rnd_ready[d] = 1'b0; out_cnt[d] = 0;
      exp_frames[d] = 0; stall_pend[d] = 1'b0; no_ready[d] = 1'b0;
      stall_val[d] = 9'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_m_tvalid", 32'(m_tvalid[d]), 32'd0);
      check("rst_m_tdata", 32'(m_tdata[d]), 32'd0);
      check("rst_m_tlast", 32'(m_tlast[d]), 32'd0);
      check("rst_s_tready", 32'(s_tready[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_frame_count", 32'(fcount[d]), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 60-byte payload, no padding, with first-byte latency check
    hdr_dst = 48'h0102_0304_0506; hdr_src = 48'hAABB_CCDD_EEFF;
    hdr_type = 16'h0800; hdr_tci = 16'h0000;
    fill_ramp(60);
    fork
      send_frame(0, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("busy_after_exit", 32'(busy[0]), 32'd1);
        check("hdr_not_yet_valid", 32'(m_tvalid[0]), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(m_tvalid[0]), 32'd1);
        check("first_byte", 32'(m_tdata[0]), 32'h01);
      end
    join
    wait_drain(0);
    check("frame_count_1", 32'(fcount[0]), 32'(exp_frames[0]));
    check("busy_idle", 32'(busy[0]), 32'd0);

    // 10-byte payload, padded to 46
    fill_ramp(10);
    send_frame(0, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
    wait_drain(0);
    check("frame_count_pad", 32'(fcount[0]), 32'(exp_frames[0]));

    // tagged frame, exactly the minimum payload
    hdr_tci = 16'h2064;
    fill_ramp(42);
    send_frame(1, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
    wait_drain(1);
    check("vlan_frame_count", 32'(fcount[1]), 32'(exp_frames[1]));

    // header inputs change mid-payload; the next frame picks them up
    fill_rand(20);
    send_frame(0, 1'b1, 48'h1122_3344_5566, 48'h0A0B_0C0D_0E0F, 16'h86DD, 16'h0001);
    fill_rand(15);
    send_frame(0, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
    wait_drain(0);

    // random back-to-back frames with random downstream stalls
    rnd_ready[0] = 1'b1;
    for (int f = 0; f < 20; f++) begin
      hdr_dst  = {16'($urandom), $urandom};
      hdr_src  = {16'($urandom), $urandom};
      hdr_type = 16'($urandom);
      fill_rand($urandom_range(1, 100));
      send_frame(0, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
    end
    wait_drain(0);
    check("frame_count_rand", 32'(fcount[0]), 32'(exp_frames[0]));
    rnd_ready[1] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      hdr_dst  = {16'($urandom), $urandom};
      hdr_tci  = 16'($urandom);
      fill_rand($urandom_range(1, 100));
      send_frame(1, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
    end
    wait_drain(1);
    check("vlan_frame_count_rand", 32'(fcount[1]), 32'(exp_frames[1]));
    rnd_ready[0] = 1'b0;
    rnd_ready[1] = 1'b0;

    // reset in the middle of a frame
    out_cnt[0] = 0;
    fill_ramp(60);
    fork
      send_frame(0, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
      begin
        int t;
        t = 0;
        while (out_cnt[0] < 30 && t < 500) begin
          @(posedge clk);
          t++;
        end
        if (out_cnt[0] < 30) fail_now("reset_point_timeout");
        #1;
        reset_n = 1'b0;
        abort   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_tvalid", 32'(m_tvalid[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_frame_count", 32'(fcount[0]), 32'd0);
        exp_q.delete();
        exp_q_vlan.delete();
        exp_frames[0] = 0;
        exp_frames[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        abort   = 1'b0;
      end
    join
    @(posedge clk);
    #1;

    // a clean frame after the abandoned one
    hdr_dst = 48'h0102_0304_0506; hdr_src = 48'hAABB_CCDD_EEFF; hdr_type = 16'h0800;
    fill_rand(30);
    send_frame(0, 1'b0, 48'd0, 48'd0, 16'd0, 16'd0);
    wait_drain(0);
    check("frame_count_after_rst", 32'(fcount[0]), 32'(exp_frames[0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
